// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter sequencer slice.
package pc_seq_pkg;

  localparam int D_DEFAULT  = 12;
  localparam int A_DEFAULT  = 5;
  localparam int CW_DEFAULT = 16;

  // Branch-target LUT index 0 never holds a target; a taken branch through it is a decode error.
  localparam int LUT_NO_TARGET = 0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Host / fetch / branch bus of the sequencer; the sequencer is the slave side.
interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int D  = D_DEFAULT,
  parameter int A  = A_DEFAULT,
  parameter int CW = CW_DEFAULT
);

  logic          Start;
  logic [D-1:0]  start_pc;
  logic          stall;
  logic          halt;
  logic          branch_en;
  logic [A-1:0]  branch_idx;
  logic [D-1:0]  lut_target;
  logic [A-1:0]  lut_addr;
  logic [D-1:0]  pc;
  logic          fetch_valid;
  logic          Done;
  logic          bad_branch;
  logic [CW-1:0] run_cycles;

  modport master (
    output Start, start_pc, stall, halt, branch_en, branch_idx, lut_target,
    input  lut_addr, pc, fetch_valid, Done, bad_branch, run_cycles
  );

  modport slave (
    input  Start, start_pc, stall, halt, branch_en, branch_idx, lut_target,
    output lut_addr, pc, fetch_valid, Done, bad_branch, run_cycles
  );

endinterface

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC register and run/halt FSM with Start/Done host handshake; taken branches
// are redirected through the external branch-target LUT in the same cycle.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int D  = D_DEFAULT,
  parameter int A  = A_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input logic           Clk,
  input logic           Reset,
  pc_sequencer_if.slave bus
);

  state_t       state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic         bad_q, bad_d;
  logic         accept;
  logic         count_en;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bad_q   <= bad_q & ~accept | bad_d & ~accept;
    end
  end

  // In RUN the priority is stall > halt > branch > sequential; IDLE and DONE only wait for Start.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    bad_d    = bad_q;
    accept   = 1'b0;
    count_en = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.Start) begin
          accept  = 1'b1;
          pc_d    = bus.start_pc;
          state_d = RUN;
        end
      end
      RUN: begin
        count_en = 1'b1;
        if (!bus.stall) begin
          if (bus.halt) begin
            state_d = DONE;
          end else if (bus.branch_en && (bus.branch_idx != A'(LUT_NO_TARGET))) begin
            pc_d = bus.lut_target;
          end else begin
            pc_d = pc_q + 1'b1;
            if (bus.branch_en) begin
              bad_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sat_counter #(.CW(CW)) u_run_cycles (
    .clk (Clk),
    .rst (Reset),
    .en  (count_en),
    .clr (accept),
    .q   (bus.run_cycles)
  );

  assign bus.lut_addr    = bus.branch_idx;
  assign bus.pc          = pc_q;
  assign bus.fetch_valid = (state_q == RUN);
  assign bus.Done        = (state_q == DONE);
  assign bus.bad_branch  = bad_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a cycle-level behavioural model.
module tb_pc_sequencer;

  localparam int D       = 12;
  localparam int A       = 5;
  localparam int CW      = 8;
  localparam int PC_MOD  = 1 << D;
  localparam int CYC_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;

  pc_sequencer_if #(.D(D), .A(A), .CW(CW)) bus ();

  pc_sequencer #(.D(D), .A(A), .CW(CW)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus.slave)
  );

  logic [D-1:0] lut_mem [2**A];
  assign bus.lut_target = lut_mem[bus.lut_addr];

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Model of the program's observable state: running / finished flags, pc, cycle count, error flag.
  bit mRun, mDone, mBad;
  int mPc, mCyc;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("pc", 32'(bus.pc), mPc);
    checkValue("fetch_valid", 32'(bus.fetch_valid), 32'(mRun));
    checkValue("Done", 32'(bus.Done), 32'(mDone));
    checkValue("bad_branch", 32'(bus.bad_branch), 32'(mBad));
    checkValue("run_cycles", 32'(bus.run_cycles), mCyc);
  endtask

  task automatic applyStimulus(input bit rst, input bit st, input int spc, input bit stl,
                               input bit hlt, input bit br, input int idx);
    reset          = rst;
    bus.Start      = st;
    bus.start_pc   = spc[D-1:0];
    bus.stall      = stl;
    bus.halt       = hlt;
    bus.branch_en  = br;
    bus.branch_idx = idx[A-1:0];
    #1;
    checkValue("lut_addr", 32'(bus.lut_addr), idx);
    if (rst) begin
      mRun = 0; mDone = 0; mBad = 0; mPc = 0; mCyc = 0;
    end else if (!mRun) begin
      if (st) begin
        mRun = 1; mDone = 0; mBad = 0; mPc = spc; mCyc = 0;
      end
    end else begin
      if (mCyc < CYC_MAX) mCyc = mCyc + 1;
      if (!stl) begin
        if (hlt) begin
          mRun = 0; mDone = 1;
        end else if (br && idx != 0) begin
          mPc = int'(lut_mem[idx]);
        end else begin
          mPc = (mPc + 1) % PC_MOD;
          if (br) mBad = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    reset          = 1'b1;
    bus.Start      = 1'b0;
    bus.start_pc   = '0;
    bus.stall      = 1'b0;
    bus.halt       = 1'b0;
    bus.branch_en  = 1'b0;
    bus.branch_idx = '0;
    for (int i = 0; i < 2**A; i++) lut_mem[i] = D'($urandom_range(0, PC_MOD - 1));
    lut_mem[3] = D'(48);
    mRun = 0; mDone = 0; mBad = 0; mPc = 0; mCyc = 0;

    // Reset, start at 9, five free-running cycles
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 9, 0, 0, 0, 0);
    checkValue("t1_start_pc", 32'(bus.pc), 9);
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkValue("t1_run_cycles", 32'(bus.run_cycles), 5);
    applyStimulus(0, 1, 300, 0, 0, 0, 0);
    checkValue("t1_start_ignored", 32'(bus.pc), 15);

    // Branch through LUT index 3 from pc 20
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 20, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 3);
    checkValue("t2_branch_pc", 32'(bus.pc), 48);

    // Stall outranks halt and branch at pc 30
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 30, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 1, 3);
    checkValue("t3_stall_pc", 32'(bus.pc), 30);
    applyStimulus(0, 0, 0, 0, 1, 1, 3);
    checkValue("t3_halt_done", 32'(bus.Done), 1);

    // Halt at 96, frozen readout, restart at 14
    applyStimulus(0, 1, 96, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 5);
    checkValue("t4_frozen_pc", 32'(bus.pc), 96);
    applyStimulus(0, 1, 14, 0, 0, 0, 0);
    checkValue("t4_restart_pc", 32'(bus.pc), 14);

    // Taken branch through index 0 at pc 7 sets the sticky flag
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 7, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkValue("t5_bad_pc", 32'(bus.pc), 8);
    checkValue("t5_bad_flag", 32'(bus.bad_branch), 1);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 5, 0, 0, 0, 0);
    checkValue("t5_bad_cleared", 32'(bus.bad_branch), 0);

    // PC wrap from 4095, then reset mid-run with Start also high
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 4095, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkValue("t6_wrap_pc", 32'(bus.pc), 0);
    applyStimulus(1, 1, 77, 0, 0, 0, 0);
    checkValue("t6_reset_pc", 32'(bus.pc), 0);
    checkValue("t6_reset_run", 32'(bus.fetch_valid), 0);

    // Run long enough for the cycle counter to saturate
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    repeat (CYC_MAX + 40) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkValue("sat_run_cycles", 32'(bus.run_cycles), CYC_MAX);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      automatic bit rst = ($urandom_range(0, 199) == 0);
      automatic bit st  = ($urandom_range(0, 3) == 0);
      automatic int spc = int'($urandom_range(0, PC_MOD - 1));
      automatic bit stl = ($urandom_range(0, 4) == 0);
      automatic bit hlt = ($urandom_range(0, 24) == 0);
      automatic bit br  = ($urandom_range(0, 3) == 0);
      automatic int idx = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 2**A - 1));
      applyStimulus(rst, st, spc, stl, hlt, br, idx);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
